// File: rtl/kmeans_sweep_ctrl.sv
// rtl/kmeans_sweep_ctrl.sv - k-means run sequencer: RAM sample sweep, centroid update, convergence check
// Optional KMEANS_ITER_STATUS_EN exposes iter_count and converged.
module kmeans_sweep_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int MAN_W    = 16,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 32,
  parameter int RAM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [MAN_W-1:0]  threshold,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              smp_ready,
  output logic              smp_valid,
  output logic              smp_last,
  output logic              upd_req,
  input  logic              upd_done,
  input  logic [MAN_W-1:0]  delta,
  output logic              interrupt,
  output logic              busy,
`ifdef KMEANS_ITER_STATUS_EN
  output logic [ITER_W-1:0] iter_count,
  output logic              converged,
`endif
  output logic              err_range
);

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, UPDATE, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic                go_q;
  logic [ADDR_W-1:0]   addr_q, addr_d, first_q, first_d, last_q, last_d;
  logic [MAN_W-1:0]    thr_q, thr_d, delta_q, delta_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [RAM_LAT-1:0]  vld_q, vld_d, lst_q, lst_d;
  logic                err_q, err_d, irq_q, irq_d;
  logic                issue, go_rise, conv_now;
`ifdef KMEANS_ITER_STATUS_EN
  logic                conv_q, conv_d;
`endif

  assign go_rise  = go & ~go_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign conv_now = (delta_q <= thr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    last_d  = last_q;
    thr_d   = thr_q;
    delta_d = delta_q;
    iter_d  = iter_q;
    err_d   = err_q;
    irq_d   = 1'b0;
    issue   = 1'b0;
`ifdef KMEANS_ITER_STATUS_EN
    conv_d  = conv_q;
`endif
    case (state_q)
      IDLE: begin
        if (go_rise) begin
          first_d = first_addr;
          last_d  = last_addr;
          thr_d   = threshold;
          err_d   = 1'b0;
          iter_d  = '0;
`ifdef KMEANS_ITER_STATUS_EN
          conv_d  = 1'b0;
`endif
          if (first_addr > last_addr) begin
            err_d   = 1'b1;
            irq_d   = 1'b1;
            state_d = DONE;
          end else begin
            addr_d  = first_addr;
            state_d = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (smp_ready) begin
          issue = 1'b1;
          if (addr_q == last_q) state_d = DRAIN;
          else                  addr_d  = addr_q + 1'b1;
        end
      end
      // Leave once the final in-flight sample is on smp_valid this cycle.
      DRAIN:  if ((vld_q << 1) == '0) state_d = UPDATE;
      UPDATE: begin
        if (upd_done) begin
          delta_d = delta;
          state_d = CHECK;
        end
      end
      CHECK: begin
        iter_d = iter_q + 1'b1;
        if (conv_now || (iter_q + 1'b1 == ITER_W'(MAX_ITER))) begin
          irq_d   = 1'b1;
          state_d = DONE;
`ifdef KMEANS_ITER_STATUS_EN
          conv_d  = conv_now;
`endif
        end else begin
          addr_d  = first_q;
          state_d = SWEEP;
        end
      end
      DONE:    if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort dominates everything, including a coincident upd_done.
    if (busy && !go) begin
      state_d = IDLE;
      addr_d  = addr_q;
      issue   = 1'b0;
      irq_d   = 1'b0;
    end
    vld_d = (busy && !go) ? '0 : ((vld_q << 1) | RAM_LAT'(issue));
    lst_d = (busy && !go) ? '0 : ((lst_q << 1) | RAM_LAT'(issue && (addr_q == last_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      addr_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      thr_q   <= '0;
      delta_q <= '0;
      iter_q  <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
`ifdef KMEANS_ITER_STATUS_EN
      conv_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      go_q    <= go;
      addr_q  <= addr_d;
      first_q <= first_d;
      last_q  <= last_d;
      thr_q   <= thr_d;
      delta_q <= delta_d;
      iter_q  <= iter_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
`ifdef KMEANS_ITER_STATUS_EN
      conv_q  <= conv_d;
`endif
    end
  end

  assign ram_cs_n  = ~issue;
  assign ram_oe_n  = ~issue;
  assign ram_addr  = addr_q;
  assign smp_valid = vld_q[RAM_LAT-1];
  assign smp_last  = lst_q[RAM_LAT-1];
  assign upd_req   = (state_q == UPDATE);
  assign interrupt = irq_q;
  assign err_range = err_q;
`ifdef KMEANS_ITER_STATUS_EN
  assign iter_count = iter_q;
  assign converged  = conv_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_kmeans_sweep_ctrl.sv
// tb/tb_kmeans_sweep_ctrl.sv - directed bench for kmeans_sweep_ctrl (MAX_ITER=3, RAM_LAT=1)
module tb_kmeans_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, go, smp_ready, upd_done;
  logic [8:0]  first_addr, last_addr, ram_addr;
  logic [15:0] threshold, delta;
  logic        ram_cs_n, ram_oe_n, smp_valid, smp_last, upd_req, interrupt, busy, err_range;
`ifdef KMEANS_ITER_STATUS_EN
  logic [7:0]  iter_count;
  logic        converged;
`endif
  int total = 0;
  int bad = 0;

  kmeans_sweep_ctrl #(.ADDR_W(9), .MAN_W(16), .ITER_W(8), .MAX_ITER(3), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .first_addr(first_addr), .last_addr(last_addr),
    .threshold(threshold), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_addr(ram_addr),
    .smp_ready(smp_ready), .smp_valid(smp_valid), .smp_last(smp_last), .upd_req(upd_req),
    .upd_done(upd_done), .delta(delta), .interrupt(interrupt), .busy(busy),
`ifdef KMEANS_ITER_STATUS_EN
    .iter_count(iter_count), .converged(converged),
`endif
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for upd_req, then pulses upd_done with the given delta.
  task automatic serve(input logic [15:0] dl, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (upd_req) seen = 1'b1;
      else cyc();
    end
    upd_done = 1'b1; delta = dl;
    cyc();
    upd_done = 1'b0; delta = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; smp_ready = 1'b0; upd_done = 1'b0; delta = '0;
    first_addr = '0; last_addr = '0; threshold = '0;
    cyc(); cyc();
    @(negedge clk);
    total++; if (ram_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", ram_cs_n); end
    total++; if (ram_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b exp=1", ram_oe_n); end
    total++; if (ram_addr !== 9'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
    total++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", smp_valid); end
    total++; if (smp_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", smp_last); end
    total++; if (upd_req !== 1'b0) begin bad++; $display("FAIL reset_upd_req got=%b exp=0", upd_req); end
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err_range !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_range); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_sweep();
    first_addr = 9'd10; last_addr = 9'd13; threshold = 16'd5; smp_ready = 1'b1; go = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (ram_addr !== 9'(10 + i)) begin bad++; $display("FAIL sweep_addr[%0d] got=%0d exp=%0d", i, ram_addr, 10 + i); end
      total++; if ({ram_cs_n, ram_oe_n} !== 2'b00) begin bad++; $display("FAIL sweep_cs_oe[%0d] got=%b exp=00", i, {ram_cs_n, ram_oe_n}); end
      total++; if (smp_valid !== (i > 0)) begin bad++; $display("FAIL sweep_valid[%0d] got=%b exp=%b", i, smp_valid, i > 0); end
      total++; if (smp_last !== 1'b0) begin bad++; $display("FAIL sweep_last[%0d] got=%b exp=0", i, smp_last); end
      cyc();
    end
    @(negedge clk);
    total++; if ({smp_valid, smp_last} !== 2'b11) begin bad++; $display("FAIL drain_valid_last got=%b exp=11", {smp_valid, smp_last}); end
    total++; if (ram_cs_n !== 1'b1) begin bad++; $display("FAIL drain_cs_n got=%b exp=1", ram_cs_n); end
    total++; if (ram_addr !== 9'd13) begin bad++; $display("FAIL drain_addr got=%0d exp=13", ram_addr); end
    total++; if (upd_req !== 1'b0) begin bad++; $display("FAIL drain_upd_req got=%b exp=0", upd_req); end
    cyc();
    @(negedge clk);
    total++; if (upd_req !== 1'b1) begin bad++; $display("FAIL update_upd_req got=%b exp=1", upd_req); end
    total++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL update_valid got=%b exp=0", smp_valid); end
    upd_done = 1'b1; delta = 16'd2;
    cyc();
    upd_done = 1'b0;
    @(negedge clk);
    total++; if ({upd_req, interrupt, busy} !== 3'b001) begin bad++; $display("FAIL check_state got=%b exp=001", {upd_req, interrupt, busy}); end
    cyc();
    @(negedge clk);
    total++; if ({interrupt, busy} !== 2'b10) begin bad++; $display("FAIL done_irq_busy got=%b exp=10", {interrupt, busy}); end
    cyc();
    @(negedge clk);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_one_pulse got=%b exp=0", interrupt); end
    go = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_converge();
    bit ok;
    first_addr = 9'd0; last_addr = 9'd2; threshold = 16'd5; smp_ready = 1'b1; go = 1'b1;
    cyc();
    serve(16'd9, ok);
    total++; if (!ok) begin bad++; $display("FAIL conv_sweep1 upd_req got=0 exp=1"); end
    @(negedge clk);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL conv_no_early_irq got=%b exp=0", interrupt); end
    serve(16'd5, ok);
    total++; if (!ok) begin bad++; $display("FAIL conv_sweep2 upd_req got=0 exp=1"); end
    @(negedge clk);
    total++; if ({interrupt, busy} !== 2'b01) begin bad++; $display("FAIL conv_check got=%b exp=01", {interrupt, busy}); end
    cyc();
    @(negedge clk);
    total++; if ({interrupt, busy, err_range} !== 3'b100) begin bad++; $display("FAIL conv_done got=%b exp=100", {interrupt, busy, err_range}); end
`ifdef KMEANS_ITER_STATUS_EN
    total++; if (iter_count !== 8'd2) begin bad++; $display("FAIL conv_iter got=%0d exp=2", iter_count); end
    total++; if (converged !== 1'b1) begin bad++; $display("FAIL conv_flag got=%b exp=1", converged); end
`endif
    go = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_max_iter();
    bit ok;
    int n_req = 0;
    first_addr = 9'd3; last_addr = 9'd4; threshold = 16'd5; smp_ready = 1'b1; go = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      serve(16'd100, ok);
      total++; if (!ok) begin bad++; $display("FAIL maxit_sweep%0d upd_req got=0 exp=1", k); end
      @(negedge clk);
      total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL maxit_check%0d irq got=%b exp=0", k, interrupt); end
      cyc();
      @(negedge clk);
      total++; if ({interrupt, busy} !== ((k == 2) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL maxit_after%0d got=%b exp=%b", k, {interrupt, busy}, (k == 2) ? 2'b10 : 2'b01); end
    end
`ifdef KMEANS_ITER_STATUS_EN
    total++; if (iter_count !== 8'd3) begin bad++; $display("FAIL maxit_iter got=%0d exp=3", iter_count); end
    total++; if (converged !== 1'b0) begin bad++; $display("FAIL maxit_flag got=%b exp=0", converged); end
`endif
    for (int i = 0; i < 10; i++) begin
      cyc(); @(negedge clk);
      if (upd_req || busy) n_req++;
    end
    total++; if (n_req !== 0) begin bad++; $display("FAIL maxit_no_4th_sweep got=%0d exp=0", n_req); end
    go = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_range_error();
    first_addr = 9'd20; last_addr = 9'd7; threshold = 16'd5; smp_ready = 1'b1; go = 1'b1;
    @(negedge clk);
    total++; if ({ram_cs_n, busy, interrupt} !== 3'b100) begin bad++; $display("FAIL range_rise got=%b exp=100", {ram_cs_n, busy, interrupt}); end
    cyc();
    @(negedge clk);
    total++; if ({interrupt, err_range, busy, ram_cs_n} !== 4'b1101) begin bad++; $display("FAIL range_done got=%b exp=1101", {interrupt, err_range, busy, ram_cs_n}); end
    cyc();
    @(negedge clk);
    total++; if ({interrupt, err_range} !== 2'b01) begin bad++; $display("FAIL range_after got=%b exp=01", {interrupt, err_range}); end
    go = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    total++; if (err_range !== 1'b1) begin bad++; $display("FAIL range_sticky got=%b exp=1", err_range); end
    cyc();
  endtask

  task automatic test_stall();
    logic       pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] eadr [5] = '{9'd30, 9'd31, 9'd31, 9'd31, 9'd32};
    logic       evld [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    first_addr = 9'd30; last_addr = 9'd32; threshold = 16'd5; go = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      smp_ready = pat[i];
      @(negedge clk);
      total++; if (ram_addr !== eadr[i]) begin bad++; $display("FAIL stall_addr[%0d] got=%0d exp=%0d", i, ram_addr, eadr[i]); end
      total++; if (ram_cs_n !== ~pat[i]) begin bad++; $display("FAIL stall_cs_n[%0d] got=%b exp=%b", i, ram_cs_n, ~pat[i]); end
      total++; if (smp_valid !== evld[i]) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=%b", i, smp_valid, evld[i]); end
      if (i == 0) begin
        total++; if (err_range !== 1'b0) begin bad++; $display("FAIL stall_err_cleared got=%b exp=0", err_range); end
      end
      cyc();
    end
    @(negedge clk);
    total++; if ({smp_valid, smp_last, ram_cs_n} !== 3'b111) begin bad++; $display("FAIL stall_drain got=%b exp=111", {smp_valid, smp_last, ram_cs_n}); end
    smp_ready = 1'b1; go = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_abort();
    int  n_bad = 0;
    bit  seen = 1'b0;
    first_addr = 9'd40; last_addr = 9'd50; threshold = 16'd5; smp_ready = 1'b1; go = 1'b1;
    cyc(); cyc(); cyc();
    go = 1'b0;
    @(negedge clk);
    total++; if (ram_cs_n !== 1'b1) begin bad++; $display("FAIL abort_sweep_cs_n got=%b exp=1", ram_cs_n); end
    for (int i = 0; i < 5; i++) begin
      cyc(); @(negedge clk);
      if (smp_valid || interrupt || busy || !ram_cs_n) n_bad++;
    end
    total++; if (n_bad !== 0) begin bad++; $display("FAIL abort_sweep_quiet got=%0d exp=0", n_bad); end
    go = 1'b1;
    cyc();
    @(negedge clk);
    total++; if ({busy, ram_addr} !== {1'b1, 9'd40}) begin bad++; $display("FAIL restart got=%b/%0d exp=1/40", busy, ram_addr); end
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc(); @(negedge clk);
      if (upd_req) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL abort_wait_update upd_req got=0 exp=1"); end
    go = 1'b0; upd_done = 1'b1; delta = 16'd0;
    cyc();
    upd_done = 1'b0;
    @(negedge clk);
    total++; if ({busy, upd_req} !== 2'b00) begin bad++; $display("FAIL abort_update got=%b exp=00", {busy, upd_req}); end
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (interrupt || smp_valid) n_bad++;
      cyc(); @(negedge clk);
    end
    total++; if (n_bad !== 0) begin bad++; $display("FAIL abort_update_no_irq got=%0d exp=0", n_bad); end
    cyc();
  endtask

  task automatic test_reset_mid();
    first_addr = 9'd5; last_addr = 9'd9; smp_ready = 1'b1; go = 1'b1;
    cyc(); cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, ram_cs_n, smp_valid} !== 3'b010) begin bad++; $display("FAIL reset_mid got=%b exp=010", {busy, ram_cs_n, smp_valid}); end
    total++; if (ram_addr !== 9'd0) begin bad++; $display("FAIL reset_mid_addr got=%0d exp=0", ram_addr); end
    go = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_converge();
    test_max_iter();
    test_range_error();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
